// File: rtl/asic_output_analyzer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | asic_output_analyzer_if                                                  |
// | XADC sample stream in, window classification and spike counts out.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface asic_output_analyzer_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      xadc_config;
  logic             sample_valid;
  logic [4:0]       sample_channel;
  logic [11:0]      sample_data;
  logic [1:0]       network_output;
  logic             result_valid;
  logic [CNT_W-1:0] spike_count0;
  logic [CNT_W-1:0] spike_count1;

  modport master (
    output xadc_config, sample_valid, sample_channel, sample_data,
    input  network_output, result_valid, spike_count0, spike_count1
  );

  modport slave (
    input  xadc_config, sample_valid, sample_channel, sample_data,
    output network_output, result_valid, spike_count0, spike_count1
  );
endinterface
`default_nettype wire

// File: rtl/asic_output_analyzer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | asic_output_analyzer                                                     |
// | Per-channel spike detection with hysteresis, windowed counting, winner.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module asic_output_analyzer #(
  parameter logic [4:0] CH0_ADDR  = 5'h10,
  parameter logic [4:0] CH1_ADDR  = 5'h11,
  parameter int         CNT_W     = 16,
  parameter int         WIN_SHIFT = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  asic_output_analyzer_if.slave  bus
);

  localparam int c_TMR_W = 12 + WIN_SHIFT;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [11:0]          r_win_field;
  logic [c_TMR_W-1:0]   r_timer;
  logic [c_TMR_W-1:0]   w_win_len;
  logic                 w_term;
  logic                 w_term_evt;
  logic [11:0]          w_thr;
  logic [11:0]          w_hyst;
  logic [11:0]          w_low;
  logic [11:0]          w_field_cfg;
  logic [CNT_W-1:0]     w_cnt0_nxt;
  logic [CNT_W-1:0]     w_cnt1_nxt;
  logic [1:0]           r_net;
  logic                 r_result_valid;
  logic [CNT_W-1:0]     r_sc0;
  logic [CNT_W-1:0]     r_sc1;

  assign w_thr       = bus.xadc_config[11:0];
  assign w_hyst      = {4'b0, bus.xadc_config[19:12]};
  assign w_field_cfg = bus.xadc_config[31:20];
  // Re-arm level saturates at zero; a zero level can never be undershot.
  assign w_low       = (w_hyst >= w_thr) ? 12'd0 : (w_thr - w_hyst);

  assign w_win_len  = {r_win_field, {WIN_SHIFT{1'b0}}};
  assign w_term     = (r_timer == (w_win_len - c_TMR_W'(1)));
  assign w_term_evt = (r_state == S_COUNT) && w_term;

  for (genvar g = 0; g < 2; g++) begin : g_ch
    localparam logic [4:0] c_ADDR = (g == 0) ? CH0_ADDR : CH1_ADDR;

    logic             r_fired;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_hit;
    logic             w_spike;
    logic             w_rearm;

    assign w_hit     = bus.sample_valid && (bus.sample_channel == c_ADDR);
    assign w_spike   = w_hit && !r_fired && (bus.sample_data >= w_thr);
    assign w_rearm   = w_hit && r_fired && (bus.sample_data < w_low);
    assign w_cnt_nxt = (w_spike && (r_cnt != {CNT_W{1'b1}})) ? (r_cnt + CNT_W'(1)) : r_cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_fired <= 1'b0;
      end else if (w_spike) begin
        r_fired <= 1'b1;
      end else if (w_rearm) begin
        r_fired <= 1'b0;
      end
    end

    // Cleared on the terminal edge so a REPORT-cycle spike lands in the new window.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt <= '0;
      end else if ((r_state == S_IDLE) || w_term_evt) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_nxt;
      end
    end
  end

  assign w_cnt0_nxt = g_ch[0].w_cnt_nxt;
  assign w_cnt1_nxt = g_ch[1].w_cnt_nxt;

  function automatic logic [1:0] classify(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    if (a > b)               return 2'b01;
    else if (b > a)          return 2'b10;
    else if (a != '0)        return 2'b11;
    else                     return 2'b00;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_field_cfg != 12'd0) w_state_nxt = S_COUNT;
      S_COUNT:  if (w_term) w_state_nxt = S_REPORT;
      S_REPORT: w_state_nxt = (w_field_cfg != 12'd0) ? S_COUNT : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_field <= '0;
      r_timer     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_win_field <= w_field_cfg;
          r_timer     <= '0;
        end
        S_COUNT: begin
          r_timer <= w_term ? '0 : (r_timer + c_TMR_W'(1));
        end
        S_REPORT: begin
          r_win_field <= w_field_cfg;
          r_timer     <= '0;
        end
        default: begin
          r_win_field <= '0;
          r_timer     <= '0;
        end
      endcase
    end
  end

  // Results are captured on the terminal edge using next-counts, so the
  // terminal-cycle sample is included and result_valid is high in REPORT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_net          <= 2'b00;
      r_result_valid <= 1'b0;
      r_sc0          <= '0;
      r_sc1          <= '0;
    end else begin
      r_result_valid <= w_term_evt;
      if (w_term_evt) begin
        r_net <= classify(w_cnt0_nxt, w_cnt1_nxt);
        r_sc0 <= w_cnt0_nxt;
        r_sc1 <= w_cnt1_nxt;
      end
    end
  end

  assign bus.network_output = r_net;
  assign bus.result_valid   = r_result_valid;
  assign bus.spike_count0   = r_sc0;
  assign bus.spike_count1   = r_sc1;

endmodule
`default_nettype wire

// File: tb/tb_asic_output_analyzer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_asic_output_analyzer                                                  |
// | Directed stimulus with a scoreboard queue and an independent monitor.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_asic_output_analyzer;

  localparam int c_CNT_W = 4;

  typedef struct {
    int                 cyc;
    logic [1:0]         no;
    logic [c_CNT_W-1:0] c0;
    logic [c_CNT_W-1:0] c1;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  asic_output_analyzer_if #(.CNT_W(c_CNT_W)) bus ();

  asic_output_analyzer #(
    .CH0_ADDR  (5'h10),
    .CH1_ADDR  (5'h11),
    .CNT_W     (c_CNT_W),
    .WIN_SHIFT (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] cfg(input int field);
    logic [31:0] f;
    f = field;
    return {f[11:0], 8'h10, 12'h800};
  endfunction

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [4:0] ch, input logic [11:0] d);
    bus.sample_channel = ch;
    bus.sample_data    = d;
    bus.sample_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_valid   = 1'b0;
  endtask

  task automatic pulse(input logic [4:0] ch);
    drive(ch, 12'h900);
    drive(ch, 12'h100);
  endtask

  task automatic push(input int c, input logic [1:0] no, input int c0, input int c1);
    exp_t e;
    e.cyc = c;
    e.no  = no;
    e.c0  = c_CNT_W'(c0);
    e.c1  = c_CNT_W'(c1);
    q.push_back(e);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_net"}, 32'(bus.network_output), 32'd0);
    chk({tag, "_rv"},  32'(bus.result_valid),   32'd0);
    chk({tag, "_sc0"}, 32'(bus.spike_count0),   32'd0);
    chk({tag, "_sc1"}, 32'(bus.spike_count1),   32'd0);
  endtask

  // Monitor: every result_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.result_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("report_cycle", 32'(cyc), 32'(e.cyc));
        chk("network_output", 32'(bus.network_output), 32'(e.no));
        chk("spike_count0", 32'(bus.spike_count0), 32'(e.c0));
        chk("spike_count1", 32'(bus.spike_count1), 32'(e.c1));
      end
    end
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int r;
    rst                = 1'b1;
    bus.xadc_config    = 32'd0;
    bus.sample_valid   = 1'b0;
    bus.sample_channel = 5'd0;
    bus.sample_data    = 12'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_cyc(cyc + 40);

    // Window 0: 5 vs 2 spikes, foreign channel ignored
    c0 = cyc;
    bus.xadc_config = cfg(1);
    r = c0 + 1025;
    push(r, 2'b01, 5, 2);
    wait_cyc(c0 + 5);
    repeat (5) pulse(5'h10);
    repeat (2) pulse(5'h11);
    repeat (3) pulse(5'h12);

    // Window 1: hysteresis, only the 0x7E0 sample re-arms
    push(r + 1025, 2'b01, 2, 0);
    wait_cyc(r + 5);
    drive(5'h10, 12'h900);
    drive(5'h10, 12'h7F8);
    drive(5'h10, 12'h900);
    drive(5'h10, 12'h7E0);
    drive(5'h10, 12'h900);
    drive(5'h10, 12'h100);
    r = r + 1025;

    // Window 2: tie
    push(r + 1025, 2'b11, 3, 3);
    wait_cyc(r + 5);
    repeat (3) pulse(5'h10);
    repeat (3) pulse(5'h11);
    r = r + 1025;

    // Window 3: empty
    push(r + 1025, 2'b00, 0, 0);
    r = r + 1025;

    // Window 4: ch1 spike in the terminal cycle, ch0 spike in REPORT cycle
    push(r + 1025, 2'b11, 1, 1);
    wait_cyc(r + 5);
    pulse(5'h10);
    r = r + 1025;
    wait_cyc(r - 1);
    drive(5'h11, 12'h900);
    drive(5'h10, 12'h900);
    drive(5'h11, 12'h100);
    drive(5'h10, 12'h100);

    // Window 5: carries the REPORT-cycle spike; field changes mid-window
    push(r + 1025, 2'b01, 1, 0);
    wait_cyc(r + 500);
    bus.xadc_config = cfg(2);
    r = r + 1025;

    // Window 6: 2048 cycles, 20 spikes saturate a 4-bit counter
    push(r + 2049, 2'b01, 15, 0);
    wait_cyc(r + 5);
    repeat (20) pulse(5'h10);
    r = r + 2049;

    // Window 7: reset mid-window with ch0 left FIRED
    wait_cyc(r + 5);
    repeat (3) pulse(5'h10);
    drive(5'h10, 12'h900);
    wait_cyc(r + 500);
    rst = 1'b1;
    bus.xadc_config = cfg(1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_zero_outputs("midrst");
    @(posedge clk);
    #1;
    c0 = cyc;
    rst = 1'b0;
    r = c0 + 1025;
    push(r, 2'b01, 2, 0);
    wait_cyc(c0 + 5);
    repeat (2) pulse(5'h10);

    // Field 0 at REPORT returns to IDLE: no further results
    wait_cyc(r - 10);
    bus.xadc_config = cfg(0);
    wait_cyc(r + 1500);
    chk("pending_reports", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/asic_output_analyzer.md
# asic_output_analyzer

Downstream stage of the ASIC bridge: consumes the XADC conversion stream that samples the neuromorphic ASIC's two output-neuron voltages and decides which neuron fired more during a fixed time window. It detects spikes per channel with a threshold and hysteresis, counts them per window, and produces the 2-bit `network_output` code that `axi_cfg_regs` exposes to software. It is configured by the 32-bit `xadc_config` word from `axi_cfg_regs`.

## Interface
Parameters:
- `CH0_ADDR`, default 5'h10: XADC channel address of output neuron 0 (VAUX0).
- `CH1_ADDR`, default 5'h11: XADC channel address of output neuron 1 (VAUX1).
- `CNT_W`, default 16: spike counter width.
- `WIN_SHIFT`, default 10: window unit is 2^WIN_SHIFT clock cycles.

Ports:
- `clk`  in  1  system clock. One clock domain only.
- `rst`  in  1  reset. Synchronous, active-high.
- `xadc_config`  in  32  configuration: [11:0] spike threshold; [19:12] hysteresis; [31:20] window length in units of 2^WIN_SHIFT cycles.
- `sample_valid`  in  1  XADC end-of-conversion strobe. One cycle per sample.
- `sample_channel`  in  5  channel address of the sample.
- `sample_data`  in  12  unsigned conversion result.
- `network_output`  out  2  classification: 00 no spikes, 01 neuron 0 wins, 10 neuron 1 wins, 11 tie with nonzero counts.
- `result_valid`  out  1  one-cycle pulse when `network_output` and the counts update.
- `spike_count0`  out  CNT_W  neuron 0 count from the last completed window.
- `spike_count1`  out  CNT_W  neuron 1 count from the last completed window.

## Operation
- Reset values: `network_output`=00, `result_valid`=0, both `spike_count*`=0, both live counters=0, both detectors ARMED, window timer=0, state IDLE.
- Each channel has a detector with states ARMED and FIRED.
  - ARMED -> FIRED when a valid sample for the channel has `sample_data` >= threshold. That transition is one spike and increments that channel's live counter.
  - FIRED -> ARMED when a valid sample has `sample_data` < threshold - hysteresis. The subtraction saturates at 0, so with hysteresis >= threshold the detector re-arms only on `sample_data` < 0, i.e. never, and stays FIRED.
  - Samples on any other channel address are ignored.
- Live counters saturate at 2^CNT_W-1 and do not wrap.
- Threshold and hysteresis are read live on every sample.
- The window length field is latched when a window starts. Changing it mid-window has no effect until the next window.
- Top-level FSM:
  - IDLE: the latched window field is 0. Timer is held at 0, counters are held at 0, and no results are produced. When a nonzero field is present, latch it and go to COUNT.
  - COUNT: the timer increments every cycle. When timer = (field << WIN_SHIFT) - 1, go to REPORT.
  - REPORT (1 cycle): copy the live counters to `spike_count*`, compute `network_output` from them, pulse `result_valid`, clear the live counters and the timer, and relatch the field. If the new field is 0, go to IDLE; otherwise go to COUNT.
- Classification: 01 if count0 > count1; 10 if count1 > count0; 11 if the counts are equal and nonzero; 00 if both are 0. The comparison is full-width unsigned.
- Detector FIRED/ARMED state persists across window boundaries and is not cleared at REPORT.

## Timing
- A spike sample accepted in cycle t is reflected in the live counter at t+1.
- A sample arriving in the final COUNT cycle counts toward the closing window.
- A sample arriving in the REPORT cycle counts toward the new window: the counter is cleared and then incremented, giving 1.
- `result_valid` rises 1 cycle after the terminal COUNT cycle. `network_output` and `spike_count*` change in the same cycle and hold until the next REPORT.
- Window period is exactly (field << WIN_SHIFT) + 1 cycles, including the REPORT cycle.
- `rst` asserted mid-window discards the live counts. Outputs return to reset values on the next edge and no `result_valid` is produced.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset check: hold `rst` for 3 cycles. All outputs are 0, and no `result_valid` appears while the window field is 0.
- Single winner: threshold=0x800, hysteresis=0x10, window=1 (1024 cycles). Drive ch 0x10 with 5 pulses 0x900/0x100 and ch 0x11 with 2 pulses. Expect `result_valid` at cycle 1025, `spike_count0`=5, `spike_count1`=2, `network_output`=01.
- Hysteresis: on ch 0x10, drive 0x900, 0x7F8, 0x900, 0x7E0, 0x900 with threshold=0x800 and hysteresis=0x10. Expect count0=2: the 0x7F8 sample does not re-arm, the 0x7E0 sample does.
- Tie and empty windows: 3 spikes on each channel gives 11. The following window with no spikes gives 00 and counts 0/0.
- Boundary samples: a spike in the terminal COUNT cycle is counted in the old window. A spike in the REPORT cycle shows as count 1 in the next report. Changing the window field from 1 to 2 mid-window keeps the current window at 1024 cycles and makes the next one 2048.
- Saturation and reset: with CNT_W=4, 20 spikes on ch0 report 15. Asserting `rst` at cycle 500 of a window means no report follows and counts restart from 0.
